// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared types and default sizing for the ALU scheduler slice.
package alu_sched_pkg;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef logic [3:0] opcode_t;
endpackage

// File: rtl/alu_sched_if.sv
// alu_sched_if: requester, ALU and response signals of the scheduler.
interface alu_sched_if #(
  parameter int NUM_REQ = alu_sched_pkg::NUM_REQ,
  parameter int DATA_W  = alu_sched_pkg::DATA_W
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0]                       req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0]           req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0]           req_b;
  alu_sched_pkg::opcode_t [NUM_REQ-1:0]     req_op;
  logic [DATA_W-1:0]                        alu_a;
  logic [DATA_W-1:0]                        alu_b;
  alu_sched_pkg::opcode_t                   alu_op;
  logic [DATA_W-1:0]                        alu_result;
  logic                                     rsp_valid;
  logic                                     rsp_ready;
  logic [IW-1:0]                            rsp_id;
  logic [DATA_W-1:0]                        rsp_data;
  logic                                     busy;
  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data, busy
  );
  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant starting at ptr_i, ascending with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] j;
  // Scan farthest-first so the requester closest to ptr_i overwrites the rest.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one registered ALU among NUM_REQ requesters, one op in flight.
module alu_scheduler #(
  parameter int NUM_REQ = alu_sched_pkg::NUM_REQ,
  parameter int DATA_W  = alu_sched_pkg::DATA_W
) (
  input logic       clk,
  input logic       rst_n,
  alu_sched_if.slave bus
);
  import alu_sched_pkg::*;
  localparam int IW = $clog2(NUM_REQ);
  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, id_q, idx;
  logic [NUM_REQ-1:0] gnt;
  logic [DATA_W-1:0] a_q, b_q, data_q;
  opcode_t           op_q;
  logic              acc;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i(bus.req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(idx)
  );
  always_comb begin
    acc = rst_n && state_q == IDLE && |bus.req_valid;
    ptr_d = acc ? (idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1) : ptr_q;
    state_d = state_q == IDLE  ? (acc ? ISSUE : IDLE) :
              state_q == ISSUE ? WAIT :
              state_q == WAIT  ? RESP :
              bus.rsp_ready    ? IDLE : RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (acc) begin
        a_q  <= bus.req_a[idx];
        b_q  <= bus.req_b[idx];
        op_q <= bus.req_op[idx];
        id_q <= idx;
      end
      if (state_q == WAIT) data_q <= bus.alu_result;
    end
  // Gated by rst_n so the grant is quiet while reset is held even with requests pending.
  assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: table-driven grant checks plus scoreboarded responses from a registered ALU model.
module tb_alu_scheduler;
  import alu_sched_pkg::*;
  typedef struct packed {logic [3:0] v; logic [3:0] g;} vec_t;
  typedef struct packed {logic [1:0] id; logic [63:0] d;} rsp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass_n = 0;
  int total_n = 0;
  vec_t tbl[10];
  rsp_t sb[$];
  rsp_t last, mon_e;
  logic [63:0] exp_a;
  always #5 clk = ~clk;
  alu_sched_if #(.NUM_REQ(4), .DATA_W(64)) bus();
  alu_scheduler #(.NUM_REQ(4), .DATA_W(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b, input opcode_t op);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[5:0];
      default: return (a ^ b) + 64'(op);
    endcase
  endfunction
  always_ff @(posedge clk) bus.alu_result <= alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  always @(negedge clk)
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_rsp_id", 64'(bus.rsp_id), 64'(mon_e.id));
        chk("sb_rsp_data", bus.rsp_data, mon_e.d);
      end
    end
  task automatic scramble;
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i]  = {$urandom, $urandom};
      bus.req_b[i]  = {$urandom, $urandom};
      bus.req_op[i] = 4'($urandom);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] v, input logic [3:0] g);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) if (g[i]) k = i;
    scramble;
    bus.req_valid = v;
    #1;
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("grant", 64'(bus.req_ready), 64'(g));
    exp_a = bus.req_a[k];
    last.id = 2'(k);
    last.d = alu_f(bus.req_a[k], bus.req_b[k], bus.req_op[k]);
    sb.push_back(last);
    tick;
    chk("alu_a_latched", bus.alu_a, exp_a);
  endtask
  task automatic complete;
    for (int c = 0; c < 2; c++) begin
      scramble;
      #1;
      chk("ready_busy", 64'(bus.req_ready), 64'd0);
      chk("rsp_early", 64'(bus.rsp_valid), 64'd0);
      tick;
    end
    chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("rsp_id", 64'(bus.rsp_id), 64'(last.id));
    tick;
  endtask
  task automatic reset_pulse;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{4'b1111, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010};
    tbl[2] = '{4'b1111, 4'b0100};
    tbl[3] = '{4'b1111, 4'b1000};
    tbl[4] = '{4'b1111, 4'b0001};
    tbl[5] = '{4'b0100, 4'b0100};
    tbl[6] = '{4'b1001, 4'b1000};
    tbl[7] = '{4'b1001, 4'b0001};
    tbl[8] = '{4'b0011, 4'b0010};
    tbl[9] = '{4'b0011, 4'b0001};
    scramble;
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_alu_a", bus.alu_a, 64'd0);
    tick;
    tick;
    rst_n = 1'b1;
    bus.req_a[0] = 64'd5;
    bus.req_b[0] = 64'd7;
    bus.req_op[0] = 4'd0;
    #1;
    chk("single_grant", 64'(bus.req_ready), 64'b0001);
    last.id = 2'd0;
    last.d = 64'd12;
    sb.push_back(last);
    tick;
    bus.req_valid = 4'b0000;
    chk("single_rsp_c1", 64'(bus.rsp_valid), 64'd0);
    tick;
    chk("single_rsp_c2", 64'(bus.rsp_valid), 64'd0);
    tick;
    chk("single_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_rsp_data", bus.rsp_data, 64'd12);
    chk("single_rsp_id", 64'(bus.rsp_id), 64'd0);
    tick;
    reset_pulse;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i].v, tbl[i].g);
      complete;
    end
    reset_pulse;
    bus.rsp_ready = 1'b0;
    issue(4'b0010, 4'b0010);
    tick;
    tick;
    for (int c = 0; c < 5; c++) begin
      bus.req_valid = 4'b1111;
      scramble;
      #1;
      chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_rsp_data", bus.rsp_data, last.d);
      chk("bp_rsp_id", 64'(bus.rsp_id), 64'd1);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    chk("sim_no_grant", 64'(bus.req_ready), 64'd0);
    chk("sim_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    tick;
    issue(4'b1111, 4'b0100);
    complete;
    issue(4'b0010, 4'b0010);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("arst_alu_a", bus.alu_a, 64'd0);
    chk("arst_alu_op", 64'(bus.alu_op), 64'd0);
    chk("arst_rsp_data", bus.rsp_data, 64'd0);
    chk("arst_rsp_id", 64'(bus.rsp_id), 64'd0);
    sb.delete();
    tick;
    chk("arst_hold_rsp", 64'(bus.rsp_valid), 64'd0);
    tick;
    rst_n = 1'b1;
    issue(4'b0110, 4'b0010);
    complete;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ALU64 instance; legal range 2..8.
REQ-002 Parameter DATA_W, default 64: operand and result width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready  output  NUM_REQ  per-requester accept; a request is accepted in a cycle where both req_valid[i] and req_ready[i] are high.
REQ-007 req_a, req_b  input  NUM_REQ x DATA_W  per-requester operands.
REQ-008 req_op  input  NUM_REQ x 4  per-requester ALU opcode.
REQ-009 alu_a, alu_b  output  DATA_W  registered operands driven to the ALU.
REQ-010 alu_op  output  4  registered opcode driven to the ALU.
REQ-011 alu_result  input  DATA_W  ALU result; it is registered inside the ALU, so it is valid one clock after alu_a/alu_b/alu_op are sampled.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_ready  input  1  response consumer ready.
REQ-014 rsp_id  output  clog2(NUM_REQ)  index of the requester that owns rsp_data.
REQ-015 rsp_data  output  DATA_W  captured ALU result.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and RESP, with one operation in flight at a time.
REQ-018 In IDLE, req_ready SHALL be one-hot on the round-robin winner among asserted req_valid, or all-zero when no req_valid is asserted; it is combinational from req_valid and the priority pointer.
REQ-019 req_ready SHALL be all-zero in ISSUE, WAIT and RESP.
REQ-020 Round robin: the search starts at pointer ptr and ascends with wrap; after a grant to g, ptr becomes (g+1) mod NUM_REQ, so a grant to NUM_REQ-1 sets ptr to 0.
REQ-021 On acceptance, the block SHALL latch the winner's a, b, op and index, and go IDLE->ISSUE; alu_a/alu_b/alu_op hold those values from ISSUE until the next acceptance.
REQ-022 ISSUE->WAIT unconditionally after one cycle; the ALU samples its inputs on this edge.
REQ-023 WAIT->RESP unconditionally after one cycle; alu_result is captured into rsp_data on this edge.
REQ-024 Latency: rsp_valid SHALL first be high in the third cycle after the accept cycle.
REQ-025 In RESP, rsp_valid=1; rsp_data and rsp_id SHALL hold stable while rsp_ready=0.
REQ-026 RESP->IDLE on the edge where rsp_ready=1; the next grant can occur in the following cycle, giving a peak throughput of one operation per 4 cycles.
REQ-027 Requests SHALL be forwarded without any opcode decode; all 16 opcodes are passed to the ALU, and the result arithmetic belongs to the ALU.
REQ-028 Operands are not changed: width is DATA_W end to end, with no extension or truncation.
REQ-029 Changes to req_valid or operands of a non-granted requester while the block is busy SHALL have no effect.
REQ-030 rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-031 While rst_n=0: state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_data=0, alu_a=0, alu_b=0, alu_op=0, busy=0, req_ready=0.
REQ-032 Reset asserted mid-operation (ISSUE/WAIT/RESP) SHALL discard the in-flight operation with no response, and the first grant after reset SHALL follow ptr=0.

Structure
REQ-033 A shared package alu_sched_pkg SHALL hold the state enum type, the opcode type (4 bits), and the default constants NUM_REQ and DATA_W.
REQ-034 The round-robin grant logic SHALL be a separate sub-module rr_arbiter with inputs req and ptr, and output a one-hot grant plus the grant index.
REQ-035 The ALU itself is not instantiated inside alu_scheduler; it is connected at the level above.

Verification
REQ-036 Single request: after reset, req_valid=0001, a=5, b=7, op=0 with an ALU model -> req_ready=0001 in cycle 0; rsp_valid in cycle 3 with rsp_data=12 and rsp_id=0.
REQ-037 Fairness: req_valid=1111 held continuously, rsp_ready=1 -> grant order 0,1,2,3,0, with one grant every 4 cycles.
REQ-038 Wrap: ptr=3 after a grant to 2, then req_valid=1001 -> grant to 3, then to 0.
REQ-039 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stay constant and req_ready=0; the grant occurs the cycle after rsp_ready=1.
REQ-040 Reset mid-op: rst_n low during WAIT -> all outputs are 0 immediately (asynchronously); no response appears; after release, req_valid=0110 grants 1.
REQ-041 Simultaneous events: rsp_ready=1 and new req_valid in RESP -> no grant in that cycle; the grant happens in the next IDLE cycle.
